seven_seg_scan_ctrl: RTL and testbench
======================================

Name: seven_seg_scan_ctrl

Overview:
Scan and content scheduler for the 4-digit seven-segment display device. It generates the digit-scan index and the blink clock, and holds four 32-bit display pages. It arbitrates page writes from two requesters and presents one page to the display device, updating it only at frame boundaries so no digit ever shows mixed old and new data.

Parameters:
SCAN_TICKS, 50000, clk cycles per digit slot (scan tick period); legal range 2..2^20
FLASH_FRAMES, 64, frames per flash_clk half-period; legal range 1..1023
PAGE_FRAMES, 256, frames each page is shown when auto-rotate is on; legal range 1..65535

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
a_req  in  1  requester A write request (high priority)
a_page  in  2  requester A target page
a_data  in  32  requester A write data
a_ack  out  1  one-cycle pulse: A write accepted
b_req  in  1  requester B write request (low priority)
b_page  in  2  requester B target page
b_data  in  32  requester B write data
b_ack  out  1  one-cycle pulse: B write accepted
rotate_en  in  1  1 = auto-advance the shown page
page_sel  in  2  page to show when rotate_en=0
Scanning  out  2  current digit index to the display device
flash_clk  out  1  blink clock to the display device
disp_num  out  32  frame-stable page contents to the display device
cur_page  out  2  index of the page now in disp_num
frame_end  out  1  one-cycle pulse on each frame boundary

Behaviour:
- Reset is synchronous (rst sampled on clk rising edge) and active-high; the one clock is clk. All outputs and state reset to 0: Scanning, flash_clk, disp_num, cur_page, acks, frame_end, all four pages, all counters.
- Prescaler counts 0..SCAN_TICKS-1. The scan tick occurs in the cycle where the count equals SCAN_TICKS-1; the count then wraps to 0.
- On each scan tick, Scanning increments mod 4.
- A frame boundary is a scan tick while Scanning==3. Scanning wraps 3->0 on that tick, and frame_end is registered high for exactly the next cycle.
- Flash counter counts frames 0..FLASH_FRAMES-1. flash_clk toggles at the frame boundary where the count wraps. The flash_clk period is 2*FLASH_FRAMES frames.
- Page-hold counter counts frames 0..PAGE_FRAMES-1 and runs only while rotate_en=1. It is cleared when rotate_en=0.
- Arbitration runs every cycle and accepts at most one write per cycle:
  - a_req has priority over b_req.
  - The granted requester's ack is high in the cycle after the sample. That requester's page register takes the data in that same cycle.
  - A requester that holds req high through its ack is served again. No ack is ever issued for a request that was not high in the previous cycle.
  - If both requesters are pending, B waits; A may starve B (fixed priority).
  - Writes to the same page from A and B in the same cycle: only A is written, only a_ack pulses.
- Page shown: at each frame boundary, cur_page/disp_num are loaded as follows.
  - rotate_en=0: cur_page <= page_sel, disp_num <= page[page_sel].
  - rotate_en=1 and the hold count wraps: cur_page <= cur_page+1 (3 wraps to 0), disp_num <= that page.
  - rotate_en=1 otherwise: cur_page is unchanged and disp_num <= page[cur_page], so a new write shows on the next frame.
- A write in the same cycle as a frame boundary is not visible until the following frame boundary. disp_num samples page contents from before that cycle's write.
- disp_num and cur_page change only on frame boundaries (and on reset). Between boundaries they are stable even if the pages, page_sel or rotate_en change.
- Toggling rotate_en takes effect at the next frame boundary. Rotation restarts counting from 0 when rotate_en rises.
- Mid-operation reset: everything returns to reset values in the next cycle; pending requests are dropped with no ack. The first frame boundary after reset is 4*SCAN_TICKS cycles after rst deasserts.

Test Plan:
1. SCAN_TICKS=4, rst then release -> Scanning sequence 0,1,2,3,0 with one step per 4 clk cycles; frame_end pulses once every 16 cycles; disp_num=0 and flash_clk=0 throughout the first frame.
2. FLASH_FRAMES=2, run 8 frames -> flash_clk toggles at frame boundaries 2,4,6,8 and reads 0,1,0,1 in successive 2-frame windows.
3. A and B request in the same cycle with a_page=1, a_data=32'h12345678, b_page=2, b_data=32'hDEADBEEF -> a_ack in cycle n+1, b_ack in cycle n+2. With page_sel=1, disp_num=32'h12345678 after the next frame boundary; with page_sel=2, disp_num=32'hDEADBEEF after the boundary following that change.
4. Write page 0 = 32'h0000ABCD exactly in the frame-boundary cycle while page_sel=0 -> disp_num still holds the old value for that frame and becomes 32'h0000ABCD at the next boundary; disp_num never changes mid-frame.
5. PAGE_FRAMES=3, rotate_en=1, pages preloaded with 1,2,3,4 -> cur_page goes 0->1->2->3->0 every 3 frames and disp_num tracks 1,2,3,4,1; dropping rotate_en with page_sel=2 gives cur_page=2 at the next boundary.
6. Assert rst for 1 cycle mid-frame while a_req is high and Scanning=2 -> all outputs are 0 the next cycle, no a_ack is issued, page contents are cleared, and the scan sequence restarts at 0.

Source files
------------

// File: rtl/seven_seg_scan_ctrl_if.sv
// seven_seg_scan_ctrl_if: two-requester page-write bus with per-requester accept pulses
interface seven_seg_scan_ctrl_if;
  logic        a_req;
  logic [1:0]  a_page;
  logic [31:0] a_data;
  logic        a_ack;
  logic        b_req;
  logic [1:0]  b_page;
  logic [31:0] b_data;
  logic        b_ack;
  modport master (output a_req, a_page, a_data, b_req, b_page, b_data, input a_ack, b_ack);
  modport slave (input a_req, a_page, a_data, b_req, b_page, b_data, output a_ack, b_ack);
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: digit scan, blink clock and frame-synchronous page display for a 4-digit display
module seven_seg_scan_ctrl #(
  parameter int SCAN_TICKS   = 50000,
  parameter int FLASH_FRAMES = 64,
  parameter int PAGE_FRAMES  = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  seven_seg_scan_ctrl_if.slave wr,
  input  logic                 rotate_en,
  input  logic [1:0]           page_sel,
  output logic [1:0]           Scanning,
  output logic                 flash_clk,
  output logic [31:0]          disp_num,
  output logic [1:0]           cur_page,
  output logic                 frame_end
);
  localparam int PW = $clog2(SCAN_TICKS);
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int HW = $clog2(PAGE_FRAMES + 1);
  logic [PW-1:0] presc;
  logic [FW-1:0] flash_cnt;
  logic [HW-1:0] hold_cnt;
  logic [31:0]   pages [4];
  logic          tick, frame, flash_wrap, hold_wrap;
  logic [1:0]    nxt_page;
  always_comb begin
    tick       = presc == PW'(SCAN_TICKS - 1);
    frame      = tick && Scanning == 2'd3;
    flash_wrap = flash_cnt == FW'(FLASH_FRAMES - 1);
    hold_wrap  = hold_cnt == HW'(PAGE_FRAMES - 1);
    nxt_page   = !rotate_en ? page_sel : hold_wrap ? cur_page + 2'd1 : cur_page;
  end
  // disp_num reads pages before this cycle's write lands, so a boundary-cycle write shows one frame later
  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      Scanning  <= '0;
      flash_cnt <= '0;
      flash_clk <= 1'b0;
      hold_cnt  <= '0;
      cur_page  <= '0;
      disp_num  <= '0;
      frame_end <= 1'b0;
      wr.a_ack  <= 1'b0;
      wr.b_ack  <= 1'b0;
      for (int i = 0; i < 4; i++) pages[i] <= '0;
    end else begin
      presc     <= tick ? '0 : presc + PW'(1);
      Scanning  <= tick ? Scanning + 2'd1 : Scanning;
      frame_end <= frame;
      if (frame) begin
        flash_cnt <= flash_wrap ? '0 : flash_cnt + FW'(1);
        flash_clk <= flash_wrap ? ~flash_clk : flash_clk;
        cur_page  <= nxt_page;
        disp_num  <= pages[nxt_page];
      end
      hold_cnt <= !rotate_en ? '0 : !frame ? hold_cnt : hold_wrap ? '0 : hold_cnt + HW'(1);
      wr.a_ack <= wr.a_req;
      wr.b_ack <= wr.b_req && !wr.a_req;
      if (wr.a_req) pages[wr.a_page] <= wr.a_data;
      else if (wr.b_req) pages[wr.b_page] <= wr.b_data;
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed and random stimulus checked against a time-based reference model
module tb_seven_seg_scan_ctrl;
  localparam int ST = 4, FF = 2, PF = 3;
  logic        clk = 1'b0, rst = 1'b1, rotate_en = 1'b0;
  logic [1:0]  page_sel = 2'd0;
  logic [1:0]  Scanning, cur_page;
  logic        flash_clk, frame_end;
  logic [31:0] disp_num;
  int          vectors = 0, miscompares = 0;
  seven_seg_scan_ctrl_if wr();
  seven_seg_scan_ctrl #(.SCAN_TICKS(ST), .FLASH_FRAMES(FF), .PAGE_FRAMES(PF)) dut (
    .clk(clk), .rst(rst), .wr(wr), .rotate_en(rotate_en), .page_sel(page_sel),
    .Scanning(Scanning), .flash_clk(flash_clk), .disp_num(disp_num),
    .cur_page(cur_page), .frame_end(frame_end));
  always #5 clk = ~clk;
  // model: k = clock edges since reset released; scan/flash/frame derive from it arithmetically
  int          k = 0, rot = 0, mcur = 0;
  logic [31:0] mp [4];
  logic [31:0] mdisp = '0;
  logic        maack = 1'b0, mback = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      k = 0; rot = 0; mcur = 0; mdisp = '0; maack = 1'b0; mback = 1'b0;
      for (int i = 0; i < 4; i++) mp[i] = '0;
    end else begin
      if (k % (4 * ST) == 4 * ST - 1) begin
        if (!rotate_en) mcur = int'(page_sel);
        else begin
          rot++;
          if (rot % PF == 0) mcur = (mcur + 1) % 4;
        end
        mdisp = mp[mcur];
      end
      if (!rotate_en) rot = 0;
      maack = wr.a_req;
      mback = wr.b_req && !wr.a_req;
      if (wr.a_req) mp[wr.a_page] = wr.a_data;
      else if (wr.b_req) mp[wr.b_page] = wr.b_data;
      k++;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask
  task automatic check_all();
    chk("scanning", 32'(Scanning), 32'((k / ST) % 4));
    chk("flash_clk", 32'(flash_clk), 32'((k / (4 * ST) / FF) % 2));
    chk("frame_end", 32'(frame_end), 32'(k > 0 && k % (4 * ST) == 0));
    chk("disp_num", disp_num, mdisp);
    chk("cur_page", 32'(cur_page), 32'(mcur));
    chk("a_ack", 32'(wr.a_ack), 32'(maack));
    chk("b_ack", 32'(wr.b_ack), 32'(mback));
  endtask
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all();
    end
  endtask
  task automatic wait_frame();
    bit got = 1'b0;
    for (int i = 0; i < 8 * ST && !got; i++) begin
      tick(1);
      got = frame_end;
    end
    vectors++;
    assert (got) else begin
      miscompares++;
      $error("FAIL frame_wait: got no frame_end expected one within %0d cycles", 8 * ST);
    end
  endtask
  task automatic wr_a(input logic [1:0] p, input logic [31:0] d);
    wr.a_req = 1'b1; wr.a_page = p; wr.a_data = d;
    tick(1);
    wr.a_req = 1'b0;
  endtask
  initial begin
    wr.a_req = 1'b0; wr.a_page = '0; wr.a_data = '0;
    wr.b_req = 1'b0; wr.b_page = '0; wr.b_data = '0;
    tick(2);
    rst = 1'b0;
    tick(16);
    chk("t1_first_frame_end", 32'(frame_end), 32'd1);
    chk("t1_disp_first_frame", disp_num, 32'd0);
    wait_frame();
    chk("t2_flash_after_2", 32'(flash_clk), 32'd1);
    wait_frame();
    wait_frame();
    chk("t2_flash_after_4", 32'(flash_clk), 32'd0);
    wr.a_req = 1'b1; wr.a_page = 2'd1; wr.a_data = 32'h12345678;
    wr.b_req = 1'b1; wr.b_page = 2'd2; wr.b_data = 32'hDEADBEEF;
    tick(1);
    chk("t3_a_ack_first", 32'(wr.a_ack), 32'd1);
    chk("t3_b_waits", 32'(wr.b_ack), 32'd0);
    wr.a_req = 1'b0;
    tick(1);
    chk("t3_b_ack_second", 32'(wr.b_ack), 32'd1);
    wr.b_req = 1'b0;
    page_sel = 2'd1;
    wait_frame();
    chk("t3_page1", disp_num, 32'h12345678);
    page_sel = 2'd2;
    wait_frame();
    chk("t3_page2", disp_num, 32'hDEADBEEF);
    page_sel = 2'd0;
    tick(15);
    wr_a(2'd0, 32'h0000ABCD);
    chk("t4_boundary", 32'(frame_end), 32'd1);
    chk("t4_old_value", disp_num, 32'd0);
    wait_frame();
    chk("t4_new_value", disp_num, 32'h0000ABCD);
    for (int i = 0; i < 4; i++) wr_a(2'(i), 32'(i + 1));
    rotate_en = 1'b1;
    repeat (3) wait_frame();
    chk("t5_rot_page", 32'(cur_page), 32'd1);
    chk("t5_rot_disp", disp_num, 32'd2);
    repeat (3) wait_frame();
    chk("t5_rot_page2", 32'(cur_page), 32'd2);
    chk("t5_rot_disp2", disp_num, 32'd3);
    repeat (6) wait_frame();
    chk("t5_rot_wrap", disp_num, 32'd1);
    rotate_en = 1'b0; page_sel = 2'd2;
    wait_frame();
    chk("t5_stop_page", 32'(cur_page), 32'd2);
    for (int i = 0; i < 8 * ST && Scanning != 2'd2; i++) tick(1);
    chk("t6_scan_at_2", 32'(Scanning), 32'd2);
    wr.a_req = 1'b1; wr.a_page = 2'd3; wr.a_data = 32'hCAFEF00D;
    rst = 1'b1;
    tick(1);
    chk("t6_no_ack", 32'(wr.a_ack), 32'd0);
    chk("t6_disp_zero", disp_num, 32'd0);
    chk("t6_scan_zero", 32'(Scanning), 32'd0);
    rst = 1'b0; wr.a_req = 1'b0; page_sel = 2'd3;
    wait_frame();
    chk("t6_page_cleared", disp_num, 32'd0);
    for (int i = 0; i < 3000; i++) begin
      wr.a_req = $urandom_range(0, 3) == 0;
      wr.a_page = 2'($urandom_range(0, 3));
      wr.a_data = $urandom;
      wr.b_req = $urandom_range(0, 1) == 0;
      wr.b_page = 2'($urandom_range(0, 3));
      wr.b_data = $urandom;
      if ($urandom_range(0, 99) == 0) rotate_en = ~rotate_en;
      if ($urandom_range(0, 29) == 0) page_sel = 2'($urandom_range(0, 3));
      rst = $urandom_range(0, 599) == 0;
      tick(1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
